seq_pattern_gen: RTL
====================

Name: seq_pattern_gen

Overview:
Serial pattern transmitter that drives single-bit stimulus streams into the team's serial sequence-detector FSMs.
- Accepts a WIDTH-bit pattern and a repeat count through a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, repeating it (load_reps+1) times.
- Signals completion with a one-cycle done pulse.
- All outputs are registered (Moore style), so the stream is glitch-free for downstream Mealy logic.

Parameters:
WIDTH, 8, pattern length in bits (>= 2)
REP_W, 4, width of repeat-count field; frame repeats load_reps+1 times (1..2^REP_W)
IDLE_BIT, 1'b0, level driven on out whenever no pattern bit is being sent

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load_valid  input  1  request to start a frame
load_ready  output  1  high only in IDLE; transfer when load_valid && load_ready at a rising edge
load_data  input  WIDTH  pattern, bit WIDTH-1 sent first
load_reps  input  REP_W  repeat count minus one
out  output  1  serial bit stream
out_valid  output  1  high on every cycle out carries a pattern bit
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (sampled only on rising clk).
- Reset values: state=IDLE, out=IDLE_BIT, out_valid=0, done=0, busy=0, load_ready=1 from the first cycle after reset.
- States:
  - IDLE -> SHIFT on handshake.
  - SHIFT -> DONE after bit 0 of the final repetition.
  - DONE -> IDLE unconditionally.
- Handshake at edge T:
  - Capture load_data into a pattern register and a shift register.
  - Set bit_cnt=WIDTH-1 and rep_cnt=load_reps.
- Cycles T+1 .. T+WIDTH*(load_reps+1): out = current MSB of shift register, out_valid=1.
- Each SHIFT edge shifts left 1 and decrements bit_cnt.
- When bit_cnt==0 and rep_cnt!=0: reload the shift register from the pattern register, set bit_cnt=WIDTH-1, decrement rep_cnt. The stream stays continuous, with no gap between repetitions.
- When bit_cnt==0 and rep_cnt==0: go to DONE. Next cycle: done=1, out=IDLE_BIT, out_valid=0, load_ready=0.
- Following cycle: IDLE, load_ready=1. Minimum spacing between the first bits of two back-to-back frames is WIDTH*(reps+1)+2 cycles.
- Counter widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - rep_cnt is REP_W bits.
  - No wrap: counters are only decremented when non-zero.
- Ignored inputs outside IDLE: load_valid, load_data and load_reps have no effect during SHIFT/DONE. Mid-frame input changes never alter the stream.
- Reset mid-frame (SHIFT or DONE): next cycle returns to reset values, with no done pulse and no further pattern bits.
- Reset and load_valid together: reset wins and no frame is accepted.
- load_reps=0: single frame of exactly WIDTH bits.
- Max load_reps (all ones): 2^REP_W repetitions.

Decomposition:
- Shared package seq_gen_pkg holds the state encoding localparams ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10 and the default WIDTH/REP_W constants. Receiver-side benches reuse them.
- One natural sub-module: piso_shift_reg. It is a WIDTH-bit parallel-in/serial-out register with load, shift and msb ports, and a synchronous reset.
- The FSM and counters stay in seq_pattern_gen.

Test Plan:
1. Reset, then load 8'b0110_1100 with reps=0 at cycle T -> out=0,1,1,0,1,1,0,0 on T+1..T+8 with out_valid=1; done=1 at T+9; load_ready=1 at T+10.
2. Load 8'hA5 with reps=2 -> 24 consecutive bits repeating 1010_0101 three times with no gap; done at T+25.
3. Change load_data to 8'hFF and hold load_valid=1 during SHIFT -> stream unchanged; second frame starts transmitting at the cycle after load_ready reasserts (T+11 for a reps=0 frame).
4. Assert reset at the 4th bit of a frame -> next cycle out=0, out_valid=0, busy=0, done never pulses; load_ready=1.
5. Reset held high with load_valid=1 -> load_ready still reads 1 but no transfer; out_valid stays 0 after reset release until a fresh handshake.
6. Loopback into a bench "11"-detector model: load 8'hFF, reps=0 -> detector output high on exactly 7 bit-cycles; load 8'hAA -> never high.

Source files
------------

// File: rtl/seq_pattern_gen_pkg.sv
// +----------------------------------------------------------------------+
// | seq_gen_pkg: state encoding and default sizes shared by the serial   |
// | pattern generator and the receiver-side benches. Rev 1.0             |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_gen_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_REP_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_pattern_gen_if.sv
// +----------------------------------------------------------------------+
// | seq_gen_if: load handshake plus serial stream of the generator.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface seq_gen_if
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [REP_W-1:0] load_reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  // master issues frames; slave is the generator
  modport master (
    output load_valid, load_data, load_reps,
    input  load_ready, out, out_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_reps,
    output load_ready, out, out_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/seq_pattern_gen_piso_shift_reg.sv
// +----------------------------------------------------------------------+
// | piso_shift_reg: parallel-in/serial-out shift register, MSB first;    |
// | vacated LSBs fill with FILL_BIT. Rev 1.0                             |
// +----------------------------------------------------------------------+
`default_nettype none

module piso_shift_reg #(
  parameter int   WIDTH    = 8,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= {WIDTH{FILL_BIT}};
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[WIDTH-2:0], FILL_BIT};
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
// +----------------------------------------------------------------------+
// | seq_pattern_gen: shifts a loaded pattern out MSB-first, repeating it |
// | load_reps+1 times, then pulses done. Rev 1.0                         |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int   WIDTH    = DEF_WIDTH,
  parameter int   REP_W    = DEF_REP_W,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  seq_gen_if.slave bus
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] BIT_ONE = 1;
  localparam logic [REP_W-1:0] REP_ONE = 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_data;
  logic             sr_msb;
  logic             handshake;

  assign handshake = bus.load_valid & ready_q;

  // The shift register doubles as the out register: it is refilled with
  // IDLE_BIT on the final bit so out idles without any output mux.
  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .FILL_BIT (IDLE_BIT)
  ) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (sr_data),
    .msb_o   (sr_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_data   = pat_q;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d   = S_SHIFT;
          pat_d     = bus.load_data;
          sr_load   = 1'b1;
          sr_data   = bus.load_data;
          bit_cnt_d = BIT_MAX;
          rep_cnt_d = bus.load_reps;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q != '0) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q - BIT_ONE;
        end else if (rep_cnt_q != '0) begin
          sr_load   = 1'b1;
          sr_data   = pat_q;
          bit_cnt_d = BIT_MAX;
          rep_cnt_d = rep_cnt_q - REP_ONE;
        end else begin
          sr_load   = 1'b1;
          sr_data   = {WIDTH{IDLE_BIT}};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered from the next state (Moore outputs).
    out_valid_d = (state_d == S_SHIFT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    ready_d     = (state_d == S_IDLE);
  end

  assign bus.out        = sr_msb;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_ready = ready_q;

endmodule

`default_nettype wire
